// File: rtl/v_hier_arb_pkg.sv
// v_hier_arb_pkg: shared types, constants and the round-robin pick function
// for the v_hier_arb sequencer.
package v_hier_arb_pkg;
  localparam int AVEC_W = 4;
  typedef enum logic {IDLE, WAIT} state_t;
  typedef struct packed {
    logic       found;
    logic [3:0] idx;
  } pick_t;
  // Searches ptr+1, ptr+2, ... modulo n; iterating downwards lets the nearest hit win.
  function automatic pick_t rr_pick(input logic [15:0] req, input logic [3:0] ptr, input int n);
    pick_t p;
    int j;
    p = '0;
    for (int k = n; k >= 1; k--) begin
      j = (int'(ptr) + k) % n;
      if (req[j]) begin
        p.found = 1'b1;
        p.idx = 4'(j);
      end
    end
    return p;
  endfunction
endpackage

// File: rtl/v_hier_rr_pick.sv
// v_hier_rr_pick: combinational rotate/priority-encode round-robin picker,
// NREQ wide, shared by arbiters in front of a single resource.
module v_hier_rr_pick import v_hier_arb_pkg::*; #(
  parameter int NREQ = 4,
  parameter int IDW = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  ptr,
  output logic            found,
  output logic [IDW-1:0]  idx
);
  pick_t p;
  always_comb begin
    p = rr_pick(16'(req), 4'(ptr), NREQ);
    found = p.found;
    idx = IDW'(p.idx);
  end
endmodule

// File: rtl/v_hier_arb.sv
// v_hier_arb: round-robin arbiter/sequencer sharing one v_hier_sub among NREQ requesters.
// Define V_HIER_ARB_STATS_EN to add saturating stat_grants/stat_conflicts counters.
module v_hier_arb import v_hier_arb_pkg::*; #(
  parameter int NREQ = 4,
  parameter int SUB_LAT = 1,
  parameter int IDW = $clog2(NREQ)
) (
  input  logic                     clk,
  input  logic                     reset_l,
  input  logic [NREQ-1:0]          req,
  input  logic [AVEC_W*NREQ-1:0]   req_avec,
  output logic [NREQ-1:0]          gnt,
  output logic [AVEC_W-1:0]        sub_avec,
  input  logic [AVEC_W-1:0]        sub_qvec,
  output logic                     rsp_valid,
  output logic [IDW-1:0]           rsp_id,
  output logic [AVEC_W-1:0]        rsp_qvec,
  output logic                     busy
`ifdef V_HIER_ARB_STATS_EN
  ,
  output logic [7:0]               stat_grants,
  output logic [7:0]               stat_conflicts
`endif
);
  localparam int CW = $clog2(SUB_LAT + 1);
  state_t            state_q, state_d;
  logic [NREQ-1:0]   gnt_q, gnt_d;
  logic [AVEC_W-1:0] avec_q, avec_d, qvec_q, qvec_d;
  logic [IDW-1:0]    id_q, id_d, ptr_q, ptr_d, win;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              vld_q, vld_d, found, grant;
  v_hier_rr_pick #(.NREQ(NREQ), .IDW(IDW)) u_pick (
    .req  (req),
    .ptr  (ptr_q),
    .found(found),
    .idx  (win)
  );
  assign grant = (state_q == IDLE) && found;
`ifdef V_HIER_ARB_STATS_EN
  logic [7:0] grants_q, grants_d, conf_q, conf_d;
  logic       multi;
  always_comb begin
    multi = |(req & (req - NREQ'(1)));
    grants_d = (grant && grants_q != 8'hFF) ? grants_q + 8'd1 : grants_q;
    conf_d = (grant && multi && conf_q != 8'hFF) ? conf_q + 8'd1 : conf_q;
  end
  always_ff @(posedge clk or negedge reset_l)
    if (!reset_l) begin
      grants_q <= '0;
      conf_q <= '0;
    end else begin
      grants_q <= grants_d;
      conf_q <= conf_d;
    end
  assign stat_grants = grants_q;
  assign stat_conflicts = conf_q;
`endif
  always_ff @(posedge clk or negedge reset_l)
    if (!reset_l) begin
      state_q <= IDLE;
      gnt_q <= '0;
      avec_q <= '0;
      id_q <= '0;
      qvec_q <= '0;
      vld_q <= 1'b0;
      ptr_q <= IDW'(NREQ - 1);
      cnt_q <= '0;
    end else begin
      state_q <= state_d;
      gnt_q <= gnt_d;
      avec_q <= avec_d;
      id_q <= id_d;
      qvec_q <= qvec_d;
      vld_q <= vld_d;
      ptr_q <= ptr_d;
      cnt_q <= cnt_d;
    end
  always_comb begin
    state_d = state_q;
    gnt_d = '0;
    avec_d = avec_q;
    id_d = id_q;
    qvec_d = qvec_q;
    vld_d = 1'b0;
    ptr_d = ptr_q;
    cnt_d = cnt_q;
    if (state_q == IDLE) begin
      if (found) begin
        gnt_d = NREQ'(1) << win;
        avec_d = req_avec[AVEC_W*win +: AVEC_W];
        id_d = win;
        ptr_d = win;
        cnt_d = CW'(SUB_LAT);
        state_d = WAIT;
      end
    end else begin
      cnt_d = cnt_q - CW'(1);
      if (cnt_q == CW'(1)) begin
        qvec_d = sub_qvec;
        vld_d = 1'b1;
        state_d = IDLE;
      end
    end
  end
  always_comb begin
    gnt = gnt_q;
    sub_avec = avec_q;
    rsp_valid = vld_q;
    rsp_id = id_q;
    rsp_qvec = qvec_q;
    busy = state_q == WAIT;
  end
endmodule

// File: tb/tb_v_hier_arb.sv
// tb_v_hier_arb: directed scoreboard bench for v_hier_arb (NREQ=4) with a
// combinational stand-in for v_hier_sub; stats checked when V_HIER_ARB_STATS_EN is defined.
module tb_v_hier_arb;
  localparam int SL = 2;
  logic        clk = 1'b0, reset_l = 1'b0;
  logic [3:0]  req = '0, gnt, sub_avec, sub_qvec, rsp_qvec;
  logic [15:0] req_avec = '0;
  logic        rsp_valid, busy;
  logic [1:0]  rsp_id;
  logic [5:0]  sb[$];
  int          n_chk = 0, n_fail = 0, g_exp = 0, c_exp = 0;
`ifdef V_HIER_ARB_STATS_EN
  logic [7:0]  stat_grants, stat_conflicts;
`endif
  v_hier_arb #(.NREQ(4), .SUB_LAT(SL)) dut (
    .clk(clk), .reset_l(reset_l), .req(req), .req_avec(req_avec), .gnt(gnt),
    .sub_avec(sub_avec), .sub_qvec(sub_qvec), .rsp_valid(rsp_valid), .rsp_id(rsp_id),
    .rsp_qvec(rsp_qvec), .busy(busy)
`ifdef V_HIER_ARB_STATS_EN
    , .stat_grants(stat_grants), .stat_conflicts(stat_conflicts)
`endif
  );
  always #5 clk = ~clk;
  function automatic logic [3:0] sub_f(input logic [3:0] a);
    return {a[2:0], a[3]} ^ 4'h6;
  endfunction
  assign sub_qvec = sub_f(sub_avec);
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic chk_reset_outs(input string tag);
    chk({tag, "_gnt"}, 32'(gnt), 0);
    chk({tag, "_sub_avec"}, 32'(sub_avec), 0);
    chk({tag, "_rsp_valid"}, 32'(rsp_valid), 0);
    chk({tag, "_rsp_id"}, 32'(rsp_id), 0);
    chk({tag, "_rsp_qvec"}, 32'(rsp_qvec), 0);
    chk({tag, "_busy"}, 32'(busy), 0);
  endtask
  // One transaction: request at a negedge, expect winner w at the next edge, result SL edges later.
  task automatic txn(input logic [3:0] r, input logic [15:0] av, input int w);
    logic [3:0] a;
    logic [5:0] e;
    @(negedge clk);
    req = r;
    req_avec = av;
    @(posedge clk);
    #1;
    a = av[4*w +: 4];
    chk("gnt", 32'(gnt), 32'(4'b1 << w));
    chk("sub_avec", 32'(sub_avec), 32'(a));
    chk("busy", 32'(busy), 1);
    sb.push_back({2'(w), sub_f(a)});
    if (g_exp < 255) g_exp++;
    if ((r & (r - 4'd1)) != 0 && c_exp < 255) c_exp++;
    for (int k = 1; k < SL; k++) begin
      @(posedge clk);
      #1;
      chk("gap_gnt", 32'(gnt), 0);
      chk("early_rsp", 32'(rsp_valid), 0);
    end
    @(posedge clk);
    #1;
    e = sb.pop_front();
    chk("rsp_valid", 32'(rsp_valid), 1);
    chk("rsp_id", 32'(rsp_id), 32'(e[5:4]));
    chk("rsp_qvec", 32'(rsp_qvec), 32'(e[3:0]));
    chk("rsp_gnt", 32'(gnt), 0);
    chk("rsp_busy", 32'(busy), 0);
  endtask
  initial begin
    #1;
    chk_reset_outs("in_reset");
    repeat (2) @(negedge clk);
    reset_l = 1'b1;
    repeat (10) begin
      @(posedge clk);
      #1;
      chk_reset_outs("idle");
    end
    txn(4'b0001, 16'h000A, 0);
    for (int i = 0; i < 8; i++) txn(4'b1111, 16'($urandom), (i + 1) % 4);
    txn(4'b0100, 16'h0C00, 2);
    txn(4'b0101, 16'h0305, 0);
    txn(4'b0101, 16'h0906, 2);
    @(negedge clk);
    req = 4'b0010;
    req_avec = 16'h00B0;
    @(posedge clk);
    #1;
    chk("pre_abort_gnt", 32'(gnt), 32'(4'b0010));
    chk("pre_abort_busy", 32'(busy), 1);
    @(negedge clk);
    req = '0;
    reset_l = 1'b0;
    g_exp = 0;
    c_exp = 0;
    #1;
    chk_reset_outs("abort");
    @(negedge clk);
    reset_l = 1'b1;
    repeat (4) begin
      @(posedge clk);
      #1;
      chk("abort_no_rsp", 32'(rsp_valid), 0);
      chk("abort_no_gnt", 32'(gnt), 0);
    end
    txn(4'b1111, 16'h4321, 0);
    @(negedge clk);
    req = '0;
    reset_l = 1'b0;
    g_exp = 0;
    c_exp = 0;
    @(negedge clk);
    reset_l = 1'b1;
`ifdef V_HIER_ARB_STATS_EN
    chk("stat_grants_rst", 32'(stat_grants), 0);
    chk("stat_conflicts_rst", 32'(stat_conflicts), 0);
`endif
    for (int i = 0; i < 10; i++) txn(4'b0011, 16'($urandom), i % 2);
`ifdef V_HIER_ARB_STATS_EN
    chk("stat_grants_10", 32'(stat_grants), 10);
    chk("stat_conflicts_10", 32'(stat_conflicts), 10);
`endif
    for (int i = 0; i < 290; i++) txn(4'b0001, 16'($urandom), 0);
`ifdef V_HIER_ARB_STATS_EN
    chk("stat_grants_sat", 32'(stat_grants), 32'(g_exp));
    chk("stat_grants_255", 32'(stat_grants), 255);
    chk("stat_conflicts_end", 32'(stat_conflicts), 32'(c_exp));
`endif
    chk("sb_empty", 32'(sb.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
